// File: rtl/regdump_pkg.sv
// Shared types and defaults for the register-file dump reader.
// Define REGDUMP_SKIP_X0_EN to start the dump at x1 instead of x0.
package regdump_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int DATA_W_DEF   = 32;

`ifdef REGDUMP_SKIP_X0_EN
    localparam int FIRST_IDX = 1;
`else
    localparam int FIRST_IDX = 0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks the register file from FIRST_IDX to NUM_REGS-1 and streams each word over valid/ready.
// Build option: REGDUMP_SKIP_X0_EN (via regdump_pkg::FIRST_IDX) skips x0.
module regfile_dump_reader
    import regdump_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              done
);

    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_IDX);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   idx_reg, idx_next;
    logic [DATA_W-1:0]   out_data_reg, out_data_next;
    logic [ADDR_W-1:0]   out_idx_reg, out_idx_next;
    logic                out_last_reg, out_last_next;
    logic                out_valid_reg, out_valid_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            out_data_reg  <= '0;
            out_idx_reg   <= '0;
            out_last_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            out_data_reg  <= out_data_next;
            out_idx_reg   <= out_idx_next;
            out_last_reg  <= out_last_next;
            out_valid_reg <= out_valid_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        out_data_next  = out_data_reg;
        out_idx_next   = out_idx_reg;
        out_last_next  = out_last_reg;
        out_valid_next = out_valid_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                // busy stays up through the done pulse, then drops here
                busy_next = 1'b0;
                if (start) begin
                    state_next = FETCH;
                    idx_next   = FIRST;
                    busy_next  = 1'b1;
                end
            end
            FETCH: begin
                out_data_next  = rd_data;
                out_idx_next   = idx_reg;
                out_last_next  = (idx_reg == LAST);
                out_valid_next = 1'b1;
                state_next     = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    if (out_last_reg) begin
                        state_next = DONE;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // idx only moves when entering FETCH, so the address holds between fetches
    assign rd_addr   = idx_reg;
    assign busy      = busy_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_idx   = out_idx_reg;
    assign out_last  = out_last_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench: register-file model, randomized backpressure, reference word list per dump.
module tb_regfile_dump_reader;
    import regdump_pkg::*;

    localparam int N  = 32;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef REGDUMP_SKIP_X0_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif
    localparam int NW = N - FIRST;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_idx;
    logic          out_last;
    logic          done;

    regfile_dump_reader #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file: synchronous write port, combinational read, x0 hardwired to zero
    logic [DW-1:0] rf [N];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;
    assign rd_data = (rd_addr == '0) ? '0 : rf[rd_addr];

    // Reference: what each register should read as at its fetch
    logic [DW-1:0] shadow [N];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        bit            last;
        int            cyc;
    } hs_t;

    hs_t hs_q[$];
    int  done_q[$];
    int  stall_cnt [N];

    // Monitor: handshakes, done pulses, hold stability, busy around done
    logic          held_prev = 1'b0;
    logic          done_prev = 1'b0;
    logic [DW-1:0] held_data;
    logic [AW-1:0] held_idx;
    logic          held_last;

    always @(negedge clk) begin
        if (rst) begin
            held_prev <= 1'b0;
            done_prev <= 1'b0;
        end else begin
            if (held_prev) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, held_data);
                check("hold_idx", out_idx, held_idx);
                check("hold_last", out_last, held_last);
            end
            if (done_prev) check("busy_after_done", busy, 1'b0);
            if (out_valid && out_ready) begin
                hs_q.push_back('{idx: int'(out_idx), data: out_data, last: out_last, cyc: cyc});
                $display("[cyc %0d] word idx=%0d data=0x%08h last=%0b", cyc, out_idx, out_data, out_last);
            end
            if (out_valid && !out_ready) stall_cnt[out_idx]++;
            if (done) begin
                done_q.push_back(cyc);
                check("busy_with_done", busy, 1'b1);
                $display("[cyc %0d] done", cyc);
            end
            held_prev <= out_valid && !out_ready;
            held_data <= out_data;
            held_idx  <= out_idx;
            held_last <= out_last;
            done_prev <= done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_write(input int a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic preload(input bit random_data);
        for (int i = 0; i < N; i++) begin
            logic [DW-1:0] d;
            d = random_data ? $urandom : DW'(32'h100 + i);
            rf_write(i, d);
            shadow[i] = (i == 0) ? '0 : d;
        end
    endtask

    // modes: 0 full rate, 1 random ready, 2 stall idx3, 3 re-pulse start at idx7,
    //        4 x5 write on edge ending its fetch, 5 x5 write one edge earlier, 6 reset at idx10
    task automatic run_dump(input int mode, output int ts);
        int  hold_left;
        bit  fired;
        bit  finished;
        hs_q.delete();
        done_q.delete();
        for (int i = 0; i < N; i++) stall_cnt[i] = 0;
        hold_left = 5;
        fired     = 1'b0;
        finished  = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        ts        = cyc;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3000 && !finished; k++) begin
            start = 1'b0;
            wr_en = 1'b0;
            case (mode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (out_valid && out_idx == 3 && hold_left > 0) begin
                        out_ready = 1'b0;
                        hold_left--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
            if (mode == 3 && !fired && out_valid && out_idx == 7) begin
                start = 1'b1;
                fired = 1'b1;
            end
            if (mode == 4 && !fired && busy && !out_valid && rd_addr == 5) begin
                wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; fired = 1'b1;
            end
            if (mode == 5 && !fired && out_valid && out_ready && out_idx == 4) begin
                wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; fired = 1'b1;
            end
            if (mode == 6 && out_valid && out_idx == 10) begin
                out_ready = 1'b0;
                rst       = 1'b1;
                tick();
                rst = 1'b0;
                check("rst_valid", out_valid, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_done", done, 1'b0);
                check("rst_data", out_data, '0);
                check("rst_idx", out_idx, '0);
                for (int j = 0; j < 6; j++) tick();
                check("rst_no_done", done_q.size(), 0);
                return;
            end
            tick();
            if (done_q.size() > 0) finished = 1'b1;
        end
        wr_en     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        if (!finished) check("done_timeout", 1'b0, 1'b1);
        for (int j = 0; j < 4; j++) tick();
    endtask

    task automatic verify(input string name, input int ts, input bit full_rate);
        int n;
        check({name, "_words"}, hs_q.size(), NW);
        check({name, "_dones"}, done_q.size(), 1);
        n = (hs_q.size() < NW) ? hs_q.size() : NW;
        for (int k = 0; k < n; k++) begin
            int e_idx;
            e_idx = FIRST + k;
            check({name, "_idx"}, hs_q[k].idx, e_idx);
            check({name, "_data"}, hs_q[k].data, shadow[e_idx]);
            check({name, "_last"}, hs_q[k].last, (k == NW - 1));
            if (full_rate) check({name, "_wcyc"}, hs_q[k].cyc, ts + 2 + 2 * k);
        end
        if (done_q.size() > 0 && hs_q.size() > 0)
            check({name, "_done_gap"}, done_q[0], hs_q[hs_q.size()-1].cyc + 2);
        if (full_rate && done_q.size() > 0)
            check({name, "_done_cyc"}, done_q[0], ts + 2 * NW + 2);
    endtask

    initial begin
        int ts;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        for (int i = 0; i < 3; i++) tick();
        check("reset_busy", busy, 1'b0);
        check("reset_valid", out_valid, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_data", out_data, '0);
        check("reset_last", out_last, 1'b0);
        check("reset_addr", rd_addr, '0);
        rst = 1'b0;
        tick();

        // ascending pattern at full rate
        preload(1'b0);
        run_dump(0, ts);
        verify("full", ts, 1'b1);

        // backpressure on idx 3
        run_dump(2, ts);
        verify("stall", ts, 1'b0);
        check("stall_cycles_idx3", stall_cnt[3], 5);

        // start while busy is ignored
        run_dump(3, ts);
        verify("repulse", ts, 1'b1);

        // reset mid-dump then a clean restart
        run_dump(6, ts);
        run_dump(0, ts);
        verify("after_rst", ts, 1'b1);

        // coherency: write on fetch edge returns old value
        run_dump(4, ts);
        verify("coh_late", ts, 1'b1);
        rf_write(5, 32'h105);
        shadow[5] = 32'hDEADBEEF;
        run_dump(5, ts);
        verify("coh_early", ts, 1'b1);
        rf_write(5, 32'h105);
        shadow[5] = 32'h105;

        // random contents with random backpressure
        for (int r = 0; r < 3; r++) begin
            preload(1'b1);
            run_dump(1, ts);
            verify("random", ts, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Debug read-out engine that sits on a spare read port of the CPU register file. On a start pulse it walks the architectural registers in ascending order. It drives the register read address, captures the combinational read data, and streams one word per register over a valid/ready interface toward the debug/display path (UART or LED mux). The block is read-only toward the register file and never stalls the core.

Parameters:
- NUM_REGS, 32, number of registers to dump; must be ≤ 2**ADDR_W.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle request to begin a dump.
- busy  out  1  high from the cycle after start is accepted until done.
- rd_addr  out  ADDR_W  register-file read address.
- rd_data  in  DATA_W  register-file combinational read data for rd_addr.
- out_valid  out  1  out_data/out_idx/out_last are valid.
- out_ready  in  1  consumer accepts the word on this cycle when out_valid is also high.
- out_data  out  DATA_W  captured register value.
- out_idx  out  ADDR_W  register number of out_data.
- out_last  out  1  high with the final word of the dump.
- done  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset values: all outputs are 0 and the FSM is in IDLE. Reset at any time, including mid-dump, takes effect on the next clk edge: out_valid=0, busy=0, no done pulse. Any partial word is discarded.
- FSM states: IDLE, FETCH, SEND, DONE.
- IDLE:
  - start=1 → FETCH, idx=FIRST_IDX (0), busy=1.
  - start is ignored in every other state.
- FETCH, one cycle:
  - rd_addr=idx.
  - Register rd_data → out_data and idx → out_idx.
  - out_last = (idx==NUM_REGS-1).
  - → SEND with out_valid=1.
- SEND:
  - out_valid=1; out_data, out_idx and out_last are held stable while out_ready=0.
  - On out_valid&&out_ready: out_valid=0. If out_last → DONE, else idx=idx+1 → FETCH.
- DONE, one cycle: done=1, busy=0 on the next cycle, → IDLE.
- rd_addr holds its last value outside FETCH. Only the FETCH-cycle value is meaningful.
- Latency:
  - start sampled at edge N → FETCH during cycle N+1 → first out_valid at cycle N+2.
  - With out_ready tied high: one word per 2 cycles, i.e. 2*NUM_REGS+2 cycles from start to done.
- Coherency: no snapshot is taken. Each word is the register value at its FETCH cycle.
  - A register-file write landing on the same edge that ends FETCH is not captured; the old value is returned.
  - A write completed before FETCH is captured.
- Register x0 reads as 0 through the register file; no special casing here unless the optional feature below is enabled.
- idx never wraps: the dump terminates at NUM_REGS-1.

Optional Feature:
REGDUMP_SKIP_X0_EN
- Defined: FIRST_IDX=1. The dump emits NUM_REGS-1 words (idx 1..NUM_REGS-1) and takes 2*(NUM_REGS-1)+2 cycles at full throughput.
- Undefined: FIRST_IDX=0 and all NUM_REGS words are emitted.
- out_last and done semantics are unchanged in both cases.

Decomposition:
- Shared package regdump_pkg holds:
  - the state enum (IDLE, FETCH, SEND, DONE);
  - NUM_REGS/ADDR_W/DATA_W defaults;
  - FIRST_IDX, derived from the macro.
- Single module. The FSM plus the capture register is small, so no sub-module.

Test Plan:
1. Preload x0=0 and xi=0x100+i (i=1..31), out_ready=1, pulse start → 32 words:
   - idx 0..31, data 0x0, 0x101..0x11F;
   - out_last only on idx 31;
   - first valid 2 cycles after start, done 66 cycles after start, busy low the cycle after done.
2. Backpressure: hold out_ready=0 for 5 cycles while idx 3 is valid → out_data=0x103, out_idx=3 stable throughout; accepted once; next word idx 4, with no skip or duplicate.
3. Re-pulse start during idx 7 → ignored; exactly 32 words total and one done pulse.
4. Assert rst for 1 cycle while idx 10 is in SEND → next cycle out_valid=0, busy=0, no done. A new start restarts at idx 0 and emits a full 32-word dump.
5. Coherency check on x5 (old value 0x105):
   - core writes x5=0xDEADBEEF on the edge ending FETCH idx5 → out_data=0x105;
   - repeat with the write one cycle earlier → out_data=0xDEADBEEF.
6. With REGDUMP_SKIP_X0_EN defined: start → 31 words, idx 1..31, out_last on idx 31, done 64 cycles after start with out_ready=1.
